// File: rtl/redmule_mx_enc_arbiter.sv
// -----------------------------------------------------------------------------
// redmule_mx_enc_arbiter
//
// Shares one redmule_mx_encoder between NUM_REQ FP16 producer streams.
// A requester is granted for a whole MX block (NUM_GROUPS beats), so blocks
// from different producers never interleave inside the encoder. Each granted
// block's owner id goes into a small tag FIFO. The encoder's value/exponent
// result is steered back to the owner at the FIFO head, so results return
// strictly in grant order.
//
// Ports
//   clk_i, rst_i          : clock (rising edge), synchronous active-high reset
//   req_valid_i/ready_o   : per-requester FP16 beat handshake
//   req_data_i            : requester r data at [r*NUM_LANES*BITW +: NUM_LANES*BITW]
//   enc_fp16_*            : beat stream towards the encoder
//   enc_val_*, enc_exp_*  : encoder value-block and shared-exponent streams
//   out_valid_o/ready_i   : per-requester result handshake
//   out_val_data_o        : result value block (shared bus)
//   out_exp_data_o        : result shared exponent (shared bus)
//   busy_o                : block in flight or results still owed
// -----------------------------------------------------------------------------
module redmule_mx_enc_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned NUM_LANES  = 8,
    parameter int unsigned BITW       = 16,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned NUM_GROUPS = DATA_W / 8 / NUM_LANES,
    parameter int unsigned TAG_DEPTH  = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,

    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ*NUM_LANES*BITW-1:0] req_data_i,

    output logic                              enc_fp16_valid_o,
    input  logic                              enc_fp16_ready_i,
    output logic [NUM_LANES*BITW-1:0]         enc_fp16_data_o,

    input  logic                              enc_val_valid_i,
    output logic                              enc_val_ready_o,
    input  logic [DATA_W-1:0]                 enc_val_data_i,

    input  logic                              enc_exp_valid_i,
    output logic                              enc_exp_ready_o,
    input  logic [7:0]                        enc_exp_data_i,

    output logic [NUM_REQ-1:0]                out_valid_o,
    input  logic [NUM_REQ-1:0]                out_ready_i,
    output logic [DATA_W-1:0]                 out_val_data_o,
    output logic [7:0]                        out_exp_data_o,

    output logic                              busy_o
);

    localparam int unsigned LANE_W = NUM_LANES * BITW;
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int unsigned PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned TCNT_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic {
        ARB,
        STREAM
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic [ID_W-1:0]   grant_next;

    logic              beat_hs;
    logic              tag_push;
    logic              tag_pop;

    logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [TCNT_W-1:0] tag_cnt_q;
    logic              tag_full;
    logic              tag_nonempty;
    logic [ID_W-1:0]   head;
    logic              res_v;

    logic [NUM_REQ-1:0][LANE_W-1:0] req_data_arr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin search: first valid requester at or above rr_ptr_q, wrapping.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a signal unassigned would infer a latch.
        winner = rr_ptr_q;
        cand   = rr_ptr_q;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant_next = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // -------------------------------------------------------------------------
    // FSM next state and stream-side outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        beat_cnt_d       = beat_cnt_q;
        req_ready_o      = '0;
        enc_fp16_valid_o = 1'b0;
        beat_hs          = 1'b0;
        tag_push         = 1'b0;

        case (state_q)
            ARB: begin
                // Refusing to grant while the tag FIFO is full means a block
                // can always record its owner on its first beat.
                if (found && !tag_full) begin
                    grant_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                // Locked to grant_q: other requesters wait even if the owner stalls.
                enc_fp16_valid_o     = req_valid_i[grant_q];
                req_ready_o[grant_q] = enc_fp16_ready_i;
                beat_hs              = req_valid_i[grant_q] & enc_fp16_ready_i;
                if (beat_hs) begin
                    tag_push = (beat_cnt_q == '0);
                    if (beat_cnt_q == CNT_W'(NUM_GROUPS - 1)) begin
                        rr_ptr_d   = grant_next;
                        beat_cnt_d = '0;
                        state_d    = ARB;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers and tag FIFO control.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst_i) begin
            state_q    <= ARB;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            if (tag_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (tag_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    // NOTE: the tag storage has no reset; an entry is only read while the
    // count says it holds a live tag, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (tag_push) begin
            tag_mem[wr_ptr_q] <= grant_q;
        end
    end

    assign tag_full     = (tag_cnt_q == TCNT_W'(TAG_DEPTH));
    assign tag_nonempty = (tag_cnt_q != '0);
    assign head         = tag_mem[rd_ptr_q];

    // -------------------------------------------------------------------------
    // Result routing: zero-latency steering to the owner of the oldest block.
    // Both encoder streams must be valid together for a result to be offered.
    // -------------------------------------------------------------------------
    assign res_v   = enc_val_valid_i & enc_exp_valid_i & tag_nonempty;
    assign tag_pop = res_v & out_ready_i[head];

    always_comb begin
        out_valid_o = '0;
        if (tag_nonempty) begin
            out_valid_o[head] = res_v;
        end
    end

    assign enc_val_ready_o = tag_nonempty & out_ready_i[head];
    assign enc_exp_ready_o = tag_nonempty & out_ready_i[head];

    assign out_val_data_o = enc_val_data_i;
    assign out_exp_data_o = enc_exp_data_i;

    // -------------------------------------------------------------------------
    // Input data mux: follows grant_q at all times, also while arbitrating.
    // -------------------------------------------------------------------------
    assign req_data_arr    = req_data_i;
    assign enc_fp16_data_o = req_data_arr[grant_q];

    assign busy_o = (state_q != ARB) | tag_nonempty;

endmodule

// File: tb/tb_redmule_mx_enc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_redmule_mx_enc_arbiter
//
// Directed bench for redmule_mx_enc_arbiter with NUM_REQ=2 and 4-beat blocks.
// A small behavioural encoder stands in for redmule_mx_encoder. After four
// accepted beats it queues one result derived from the high byte h of lane 0
// of the block's first beat: exponent = h + 0x3C, every value byte = h + 0x34.
// So 0x3C00 gives 0x78/0x70 and 0x4000 gives 0x7C/0x74, which tells the
// owners' results apart on the shared bus.
// -----------------------------------------------------------------------------
module tb_redmule_mx_enc_arbiter;

    localparam int NREQ = 2;
    localparam int NL   = 8;
    localparam int BW   = 16;
    localparam int DW   = 256;
    localparam int NG   = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*NL*BW-1:0] req_data_i;
    logic                  enc_fp16_valid_o;
    logic                  enc_fp16_ready_i;
    logic [NL*BW-1:0]      enc_fp16_data_o;
    logic                  enc_val_valid_i;
    logic                  enc_val_ready_o;
    logic [DW-1:0]         enc_val_data_i;
    logic                  enc_exp_valid_i;
    logic                  enc_exp_ready_o;
    logic [7:0]            enc_exp_data_i;
    logic [NREQ-1:0]       out_valid_o;
    logic [NREQ-1:0]       out_ready_i;
    logic [DW-1:0]         out_val_data_o;
    logic [7:0]            out_exp_data_o;
    logic                  busy_o;

    always #5 clk_i = ~clk_i;

    redmule_mx_enc_arbiter #(
        .NUM_REQ   (NREQ),
        .NUM_LANES (NL),
        .BITW      (BW),
        .DATA_W    (DW),
        .TAG_DEPTH (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_data_i       (req_data_i),
        .enc_fp16_valid_o (enc_fp16_valid_o),
        .enc_fp16_ready_i (enc_fp16_ready_i),
        .enc_fp16_data_o  (enc_fp16_data_o),
        .enc_val_valid_i  (enc_val_valid_i),
        .enc_val_ready_o  (enc_val_ready_o),
        .enc_val_data_i   (enc_val_data_i),
        .enc_exp_valid_i  (enc_exp_valid_i),
        .enc_exp_ready_o  (enc_exp_ready_o),
        .enc_exp_data_i   (enc_exp_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_val_data_o   (out_val_data_o),
        .out_exp_data_o   (out_exp_data_o),
        .busy_o           (busy_o)
    );

    // ---------------- behavioural encoder ----------------
    logic [7:0] st_exp [8];
    logic [7:0] st_val [8];
    logic [3:0] st_wr, st_rd;
    int         st_beats, st_total;
    logic [7:0] st_hi, st_hi_now;
    logic       exp_kill;

    assign st_hi_now       = (st_beats == 0) ? enc_fp16_data_o[15:8] : st_hi;
    assign enc_val_valid_i = (st_wr != st_rd);
    assign enc_exp_valid_i = (st_wr != st_rd) & ~exp_kill;
    assign enc_val_data_i  = {32{st_val[st_rd[2:0]]}};
    assign enc_exp_data_i  = st_exp[st_rd[2:0]];

    always @(posedge clk_i) begin
        if (rst_i) begin
            st_wr    <= '0;
            st_rd    <= '0;
            st_beats <= 0;
            st_total <= 0;
            st_hi    <= '0;
        end else begin
            if (enc_fp16_valid_o && enc_fp16_ready_i) begin
                st_total <= st_total + 1;
                st_hi    <= st_hi_now;
                if (st_beats == NG - 1) begin
                    st_exp[st_wr[2:0]] <= st_hi_now + 8'h3C;
                    st_val[st_wr[2:0]] <= st_hi_now + 8'h34;
                    st_wr              <= st_wr + 1'b1;
                    st_beats           <= 0;
                end else begin
                    st_beats <= st_beats + 1;
                end
            end
            if (enc_val_valid_i && enc_exp_valid_i && enc_val_ready_o && enc_exp_ready_o)
                st_rd <= st_rd + 1'b1;
        end
    end

    // ---------------- bench state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc;
    int         blocks_left [NREQ];
    int         sent [NREQ];
    logic       hold [NREQ];
    int         hs_log [128];
    int         grant_seq [$];
    int         res_owner [$];
    logic [7:0] res_exp [$];
    logic [7:0] res_val [$];
    int         max_tag;

    task automatic set_data(input int r, input logic [15:0] w);
        for (int l = 0; l < NL; l++) req_data_i[(r*NL+l)*BW +: BW] = w;
    endtask

    task automatic drive_valids();
        for (int r = 0; r < NREQ; r++)
            req_valid_i[r] = (blocks_left[r] > 0) && !hold[r];
    endtask

    task automatic clear_bench();
        for (int r = 0; r < NREQ; r++) begin
            blocks_left[r] = 0;
            sent[r]        = 0;
            hold[r]        = 1'b0;
        end
        for (int i = 0; i < 128; i++) hs_log[i] = -2;
        grant_seq.delete();
        res_owner.delete();
        res_exp.delete();
        res_val.delete();
        cyc     = 0;
        max_tag = 0;
    endtask

    // Logs the current (settled) cycle, advances one edge, updates requester
    // valids from the block budget and leaves the next cycle settled.
    task automatic cycle();
        int hs;
        hs = -1;
        for (int r = 0; r < NREQ; r++)
            if (req_valid_i[r] && req_ready_o[r]) hs = r;
        if (cyc < 128) hs_log[cyc] = hs;
        if (hs >= 0 && (sent[hs] % NG) == 0) grant_seq.push_back(hs);
        for (int r = 0; r < NREQ; r++)
            if (out_valid_o[r] && out_ready_i[r]) begin
                res_owner.push_back(r);
                res_exp.push_back(out_exp_data_o);
                res_val.push_back(out_val_data_o[7:0]);
            end
        if (int'(dut.tag_cnt_q) > max_tag) max_tag = int'(dut.tag_cnt_q);
        @(posedge clk_i);
        #1;
        if (hs >= 0) begin
            sent[hs]++;
            if ((sent[hs] % NG) == 0 && blocks_left[hs] > 0) blocks_left[hs]--;
        end
        drive_valids();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_bench();
        drive_valids();
        out_ready_i      = 2'b11;
        enc_fp16_ready_i = 1'b1;
        exp_kill         = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_data(0, 16'h1111);
        set_data(1, 16'h2222);
        do_reset();
        n_vec++;
        if ({req_ready_o, enc_fp16_valid_o, out_valid_o, busy_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {req_ready_o, enc_fp16_valid_o, out_valid_o, busy_o});
        end
        n_vec++;
        if ({enc_val_ready_o, enc_exp_ready_o} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_enc_ready: got %b want 00", {enc_val_ready_o, enc_exp_ready_o});
        end
        n_vec++;
        if (enc_fp16_data_o !== {8{16'h1111}}) begin
            n_err++;
            $display("FAIL reset_data_mux: got %h want req0 slice", enc_fp16_data_o);
        end
    endtask

    task automatic test_single_block();
        do_reset();
        set_data(0, 16'h3C00);
        exp_kill       = 1'b1;
        blocks_left[0] = 1;
        drive_valids();
        #1;
        n_vec++;
        if ({req_ready_o, enc_fp16_valid_o} !== 3'b000) begin
            n_err++;
            $display("FAIL single_arb_cycle: got %b want 000", {req_ready_o, enc_fp16_valid_o});
        end
        cycle();
        n_vec++;
        if ({req_ready_o, enc_fp16_valid_o} !== 3'b011) begin
            n_err++;
            $display("FAIL single_grant: got %b want 011", {req_ready_o, enc_fp16_valid_o});
        end
        for (int k = 0; k < NG; k++) begin
            n_vec++;
            if (enc_fp16_data_o !== {8{16'h3C00}}) begin
                n_err++;
                $display("FAIL single_beat_data[%0d]: got %h want all 3c00", k, enc_fp16_data_o);
            end
            cycle();
        end
        n_vec++;
        if (sent[0] !== 4 || hs_log[0] !== -1 || hs_log[4] !== 0) begin
            n_err++;
            $display("FAIL single_beat_count: got %0d beats want 4", sent[0]);
        end
        // Exponent stream withheld: nothing may be offered, readies still follow the head.
        n_vec++;
        if ({out_valid_o, enc_val_ready_o, enc_exp_ready_o, busy_o, req_ready_o} !== 7'b0011100) begin
            n_err++;
            $display("FAIL single_half_result: got %b want 0011100",
                     {out_valid_o, enc_val_ready_o, enc_exp_ready_o, busy_o, req_ready_o});
        end
        exp_kill = 1'b0;
        #1;
        n_vec++;
        if (out_valid_o !== 2'b01 || out_exp_data_o !== 8'h78 || out_val_data_o !== {32{8'h70}}) begin
            n_err++;
            $display("FAIL single_result: got v=%b e=%h d=%h want v=01 e=78 d=all 70",
                     out_valid_o, out_exp_data_o, out_val_data_o);
        end
        cycle();
        cycle();
        cycle();
        n_vec++;
        if ({busy_o, out_valid_o} !== 3'b000 || st_total !== 4 || res_owner.size() !== 1) begin
            n_err++;
            $display("FAIL single_drain: got busy=%b v=%b beats=%0d pops=%0d want 0 00 4 1",
                     busy_o, out_valid_o, st_total, res_owner.size());
        end
    endtask

    task automatic test_simultaneous();
        int exp_hs [10] = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1};
        do_reset();
        set_data(0, 16'h3C00);
        set_data(1, 16'h4000);
        blocks_left[0] = 1;
        blocks_left[1] = 1;
        drive_valids();
        #1;
        for (int c = 0; c < 12; c++) cycle();
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (hs_log[c] !== exp_hs[c]) begin
                n_err++;
                $display("FAIL simult_hs[%0d]: got %0d want %0d", c, hs_log[c], exp_hs[c]);
            end
        end
        n_vec++;
        if (res_owner.size() !== 2) begin
            n_err++;
            $display("FAIL simult_results: got %0d results want 2", res_owner.size());
        end else if (res_owner[0] !== 0 || res_owner[1] !== 1 || res_exp[0] !== 8'h78 ||
                     res_exp[1] !== 8'h7C || res_val[1] !== 8'h74) begin
            n_err++;
            $display("FAIL simult_results: got owners %0d,%0d exps %h,%h want 0,1 78,7c",
                     res_owner[0], res_owner[1], res_exp[0], res_exp[1]);
        end
    endtask

    task automatic test_mid_block_stall();
        int exp_hs [10] = '{-1, 0, 0, -1, -1, -1, 0, 0, -1, 1};
        int guard;
        do_reset();
        set_data(0, 16'h3C00);
        set_data(1, 16'h4000);
        blocks_left[0] = 1;
        blocks_left[1] = 1;
        drive_valids();
        #1;
        guard = 0;
        while (sent[0] < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        hold[0] = 1'b1;
        drive_valids();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (req_ready_o !== 2'b01 || enc_fp16_valid_o !== 1'b0 || dut.grant_q !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b grant=%0d want 01 0 0",
                         k, req_ready_o, enc_fp16_valid_o, dut.grant_q);
            end
            cycle();
        end
        hold[0] = 1'b0;
        drive_valids();
        #1;
        guard = 0;
        while ((blocks_left[0] > 0 || blocks_left[1] > 0 || res_owner.size() < 2) && guard < 30) begin
            cycle();
            guard++;
        end
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (hs_log[c] !== exp_hs[c]) begin
                n_err++;
                $display("FAIL stall_hs[%0d]: got %0d want %0d", c, hs_log[c], exp_hs[c]);
            end
        end
        n_vec++;
        if (res_owner.size() !== 2 || sent[0] !== 4 || sent[1] !== 4) begin
            n_err++;
            $display("FAIL stall_complete: got results=%0d beats=%0d/%0d want 2 4/4",
                     res_owner.size(), sent[0], sent[1]);
        end
    endtask

    task automatic test_backpressure();
        int exp_hs [15] = '{-1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1, -1, -1, -1, -1};
        int owners [3]  = '{0, 1, 0};
        logic [7:0] exps [3] = '{8'h78, 8'h7C, 8'h78};
        int guard;
        do_reset();
        set_data(0, 16'h3C00);
        set_data(1, 16'h4000);
        out_ready_i    = 2'b10;
        blocks_left[0] = 2;
        blocks_left[1] = 1;
        drive_valids();
        #1;
        for (int c = 0; c < 5; c++) cycle();
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (out_valid_o !== 2'b01 || {enc_val_ready_o, enc_exp_ready_o} !== 2'b00 ||
                out_exp_data_o !== 8'h78 || out_val_data_o[7:0] !== 8'h70) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b e=%h want 01 00 78",
                         k, out_valid_o, {enc_val_ready_o, enc_exp_ready_o}, out_exp_data_o);
            end
            cycle();
        end
        for (int c = 0; c < 15; c++) begin
            n_vec++;
            if (hs_log[c] !== exp_hs[c]) begin
                n_err++;
                $display("FAIL bp_hs[%0d]: got %0d want %0d", c, hs_log[c], exp_hs[c]);
            end
        end
        n_vec++;
        if (max_tag !== 2) begin
            n_err++;
            $display("FAIL bp_fifo_fill: got max count %0d want 2", max_tag);
        end
        out_ready_i = 2'b11;
        #1;
        guard = 0;
        while ((blocks_left[0] > 0 || res_owner.size() < 3) && guard < 30) begin
            cycle();
            guard++;
        end
        n_vec++;
        if (res_owner.size() !== 3) begin
            n_err++;
            $display("FAIL bp_order: got %0d results want 3", res_owner.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (res_owner[i] !== owners[i] || res_exp[i] !== exps[i]) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: got owner %0d exp %h want %0d %h",
                             i, res_owner[i], res_exp[i], owners[i], exps[i]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int guard;
        do_reset();
        set_data(0, 16'h3C00);
        set_data(1, 16'h4000);
        blocks_left[0] = 3;
        blocks_left[1] = 3;
        drive_valids();
        #1;
        guard = 0;
        while ((blocks_left[0] > 0 || blocks_left[1] > 0 || res_owner.size() < 6) && guard < 60) begin
            cycle();
            guard++;
        end
        n_vec++;
        if (grant_seq.size() !== 6) begin
            n_err++;
            $display("FAIL fair_count: got %0d grants want 6", grant_seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (grant_seq[i] !== (i % 2)) begin
                    n_err++;
                    $display("FAIL fair_seq[%0d]: got %0d want %0d", i, grant_seq[i], i % 2);
                end
            end
        end
        n_vec++;
        if (max_tag > 2 || res_owner.size() !== 6) begin
            n_err++;
            $display("FAIL fair_fifo: got max count %0d results %0d want <=2 6",
                     max_tag, res_owner.size());
        end
    endtask

    task automatic test_reset_mid_block();
        int guard;
        do_reset();
        set_data(0, 16'h3C00);
        set_data(1, 16'h4000);
        blocks_left[0] = 1;
        blocks_left[1] = 1;
        drive_valids();
        #1;
        guard = 0;
        while (sent[1] < 2 && guard < 30) begin
            cycle();
            guard++;
        end
        n_vec++;
        if (sent[1] !== 2 || dut.rr_ptr_q !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_setup: got beats=%0d rr=%0d want 2 1", sent[1], dut.rr_ptr_q);
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        clear_bench();
        blocks_left[0] = 1;
        blocks_left[1] = 1;
        drive_valids();
        #1;
        n_vec++;
        if ({req_ready_o, enc_fp16_valid_o, out_valid_o, busy_o, enc_val_ready_o, enc_exp_ready_o} !== 8'b0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got %b want 00000000",
                     {req_ready_o, enc_fp16_valid_o, out_valid_o, busy_o, enc_val_ready_o, enc_exp_ready_o});
        end
        n_vec++;
        if (dut.rr_ptr_q !== 1'b0 || dut.tag_cnt_q !== 2'd0 || enc_fp16_data_o !== {8{16'h3C00}}) begin
            n_err++;
            $display("FAIL rstmid_state: got rr=%0d cnt=%0d want 0 0", dut.rr_ptr_q, dut.tag_cnt_q);
        end
        cycle();
        n_vec++;
        if (req_ready_o !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_regrant: got ready %b want 01", req_ready_o);
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        req_valid_i      = '0;
        req_data_i       = '0;
        out_ready_i      = 2'b11;
        enc_fp16_ready_i = 1'b1;
        exp_kill         = 1'b0;
        clear_bench();
        test_reset();
        test_single_block();
        test_simultaneous();
        test_mid_block_stall();
        test_backpressure();
        test_fairness();
        test_reset_mid_block();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
